// File: rtl/hwpe_stream_fence_buffered_if.sv
// HWPE-Stream channel: valid/ready handshake carrying one data word plus byte strobes.
// The master drives the beat and the slave answers with ready.
interface hwpe_stream_fence_buffered_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master (output valid, data, strb, input  ready);
  modport slave  (input  valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_fence_buffered.sv
// Multi-stream fence: each input stream fills its own small FIFO, and every enabled
// output presents one aligned beat that retires across all enabled streams at once.
module hwpe_stream_fence_buffered #(
  parameter int unsigned NB_STREAMS = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  test_mode_i,
  input  logic [NB_STREAMS-1:0] enable_mask_i,
  hwpe_stream_fence_buffered_if.slave  push_i [NB_STREAMS],
  hwpe_stream_fence_buffered_if.master pop_o  [NB_STREAMS],
  output logic [NB_STREAMS-1:0] skew_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } beat_t;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [NB_STREAMS-1:0] nonempty;
  logic [NB_STREAMS-1:0] push_ready;
  logic [NB_STREAMS-1:0] push_en;
  logic [NB_STREAMS-1:0] pop_ready;
  logic [NB_STREAMS-1:0] pop_en;
  logic                  out_valid;
  logic                  fire;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // NOTE: every output of an always_comb is assigned first, so no path can infer a latch.
  always_comb begin
    out_valid = (enable_mask_i != '0) & (&(nonempty | ~enable_mask_i));
    fire      = out_valid & (&(pop_ready | ~enable_mask_i));
    pop_en    = {NB_STREAMS{fire}} & enable_mask_i;
    skew_o    = enable_mask_i & nonempty & {NB_STREAMS{~out_valid}};
  end

  for (genvar gs = 0; gs < NB_STREAMS; gs++) begin : g_stream
    beat_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [CNT_W-1:0]  cnt_q;
    beat_t             head;

    assign nonempty[gs]   = (cnt_q != '0);
    assign push_ready[gs] = enable_mask_i[gs] & (cnt_q != FULL_CNT);
    assign push_en[gs]    = push_i[gs].valid & push_ready[gs];
    assign push_i[gs].ready = push_ready[gs];
    assign pop_ready[gs]  = pop_o[gs].ready;

    assign head            = nonempty[gs] ? mem_q[rptr_q] : '0;
    assign pop_o[gs].valid = out_valid & enable_mask_i[gs];
    assign pop_o[gs].data  = head.data;
    assign pop_o[gs].strb  = head.strb;

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else if (clear_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push_en[gs]) wptr_q <= ptr_inc(wptr_q);
        if (pop_en[gs])  rptr_q <= ptr_inc(rptr_q);
        if (push_en[gs] && !pop_en[gs])      cnt_q <= cnt_q + 1'b1;
        else if (!push_en[gs] && pop_en[gs]) cnt_q <= cnt_q - 1'b1;
      end
    end

    // NOTE: storage is reset so outputs are defined from power-up; clear only rewinds pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j < int'(FIFO_DEPTH); j++) mem_q[j] <= '0;
      end else if (push_en[gs] && !clear_i) begin
        mem_q[wptr_q] <= '{data: push_i[gs].data, strb: push_i[gs].strb};
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_fence_buffered.sv
// Directed bench for the buffered fence: a per-stream scoreboard of pushed beats is
// compared against the aligned pop outputs, with handshake and skew flags checked each step.
module tb_hwpe_stream_fence_buffered;

  localparam int unsigned NB = 2;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clear;
  logic [NB-1:0] mask;
  logic [NB-1:0] pv;
  logic [DW-1:0] pd [NB];
  logic [NB-1:0] pr;

  logic [NB-1:0] push_rdy;
  logic [NB-1:0] pop_vld;
  logic [DW-1:0] pop_dat [NB];
  logic [3:0]    pop_strb [NB];
  logic [NB-1:0] skew;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] sb0 [$];
  logic [DW-1:0] sb1 [$];

  hwpe_stream_fence_buffered_if #(.DATA_WIDTH(DW)) push_if [NB] ();
  hwpe_stream_fence_buffered_if #(.DATA_WIDTH(DW)) pop_if  [NB] ();

  for (genvar g = 0; g < NB; g++) begin : g_conn
    assign push_if[g].valid = pv[g];
    assign push_if[g].data  = pd[g];
    assign push_if[g].strb  = 4'hF;
    assign push_rdy[g]      = push_if[g].ready;
    assign pop_if[g].ready  = pr[g];
    assign pop_vld[g]       = pop_if[g].valid;
    assign pop_dat[g]       = pop_if[g].data;
    assign pop_strb[g]      = pop_if[g].strb;
  end

  hwpe_stream_fence_buffered #(
    .NB_STREAMS(NB),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .test_mode_i  (1'b0),
    .enable_mask_i(mask),
    .push_i       (push_if),
    .pop_o        (pop_if),
    .skew_o       (skew)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares the aligned outputs with the scoreboard heads; retire when a fire is expected.
  task automatic expect_pop(input string tag, input logic [NB-1:0] exp_v, input bit retire);
    check({tag, " valid"}, 64'(pop_vld), 64'(exp_v));
    if (exp_v[0]) begin
      if (sb0.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL %s sb0: observed empty, expected entry", tag);
      end else begin
        check({tag, " data0"}, 64'(pop_dat[0]), 64'(sb0[0]));
        check({tag, " strb0"}, 64'(pop_strb[0]), 64'(4'hF));
        if (retire) void'(sb0.pop_front());
      end
    end
    if (exp_v[1]) begin
      if (sb1.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL %s sb1: observed empty, expected entry", tag);
      end else begin
        check({tag, " data1"}, 64'(pop_dat[1]), 64'(sb1[0]));
        if (retire) void'(sb1.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    pv = 2'b11; pd[0] = d0; pd[1] = d1;
    sb0.push_back(d0);
    sb1.push_back(d1);
  endtask

  initial begin
    rst_ni = 1'b0; clear = 1'b0; mask = 2'b11; pv = '0; pd[0] = '0; pd[1] = '0; pr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst pop valid", 64'(pop_vld), 64'(2'b00));
    check("rst data0",     64'(pop_dat[0]), 64'(0));
    check("rst data1",     64'(pop_dat[1]), 64'(0));
    check("rst strb0",     64'(pop_strb[0]), 64'(0));
    check("rst skew",      64'(skew), 64'(2'b00));
    check("rst push rdy",  64'(push_rdy), 64'(2'b11));
    mask = 2'b01;
    #1;
    check("rst push rdy mask01", 64'(push_rdy), 64'(2'b01));
    mask = 2'b11;
    @(negedge clk);
    rst_ni = 1'b1;

    // Aligned streaming, one beat per cycle on both streams
    for (int k = 0; k < 5; k++) begin
      step();
      pr = 2'b11;
      if (k < 4) push2(32'h10 + k, 32'h20 + k);
      else pv = '0;
      #1;
      check("t1 push rdy", 64'(push_rdy), 64'(2'b11));
      if (k == 0) check("t1 c0 valid", 64'(pop_vld), 64'(2'b00));
      else        expect_pop("t1 stream", 2'b11, 1'b1);
    end
    step(); pv = '0; #1;
    check("t1 drained", 64'(pop_vld), 64'(2'b00));

    // Skew: stream0 runs two beats ahead of stream1
    step(); pv = 2'b01; pd[0] = 32'hA0; sb0.push_back(32'hA0); #1;
    check("t2 c0 skew",  64'(skew), 64'(2'b00));
    check("t2 c0 valid", 64'(pop_vld), 64'(2'b00));
    step(); pd[0] = 32'hA1; sb0.push_back(32'hA1); #1;
    check("t2 c1 skew",  64'(skew), 64'(2'b01));
    check("t2 c1 valid", 64'(pop_vld), 64'(2'b00));
    check("t2 c1 rdy",   64'(push_rdy), 64'(2'b11));
    for (int c = 2; c < 5; c++) begin
      step(); pv = '0; #1;
      check("t2 full rdy", 64'(push_rdy), 64'(2'b10));
      check("t2 skew",     64'(skew), 64'(2'b01));
    end
    step(); pv = 2'b10; pd[1] = 32'hB0; sb1.push_back(32'hB0); #1;
    check("t2 c5 skew",  64'(skew), 64'(2'b01));
    check("t2 c5 valid", 64'(pop_vld), 64'(2'b00));
    step(); pv = '0; #1;
    expect_pop("t2 c6 fire", 2'b11, 1'b1);
    check("t2 c6 skew", 64'(skew), 64'(2'b00));
    check("t2 c6 rdy",  64'(push_rdy), 64'(2'b10));
    step(); pv = 2'b10; pd[1] = 32'hB1; sb1.push_back(32'hB1); #1;
    check("t2 c7 valid", 64'(pop_vld), 64'(2'b00));
    check("t2 c7 skew",  64'(skew), 64'(2'b01));
    check("t2 c7 rdy",   64'(push_rdy), 64'(2'b11));
    step(); pv = '0; #1;
    expect_pop("t2 c8 fire", 2'b11, 1'b1);
    step(); #1;
    check("t2 drained valid", 64'(pop_vld), 64'(2'b00));
    check("t2 drained skew",  64'(skew), 64'(2'b00));

    // Partial backpressure holds the group
    step(); push2(32'hC0, 32'hD0); pr = 2'b01; #1;
    for (int c = 0; c < 3; c++) begin
      step(); pv = '0; #1;
      expect_pop("t3 hold", 2'b11, 1'b0);
    end
    step(); pr = 2'b11; #1;
    expect_pop("t3 release", 2'b11, 1'b1);
    step(); #1;
    check("t3 drained", 64'(pop_vld), 64'(2'b00));

    // Mask: only stream0 participates
    step(); mask = 2'b01; pv = 2'b11; pd[0] = 32'h55; pd[1] = 32'h66; sb0.push_back(32'h55); #1;
    check("t4 rdy",   64'(push_rdy), 64'(2'b01));
    check("t4 valid", 64'(pop_vld), 64'(2'b00));
    step(); pv = '0; #1;
    expect_pop("t4 pop", 2'b01, 1'b1);
    check("t4 data1 zero", 64'(pop_dat[1]), 64'(0));
    step(); #1;
    check("t4 drained", 64'(pop_vld), 64'(2'b00));
    step(); mask = 2'b11; #1;
    check("t4 s1 empty skew",  64'(skew), 64'(2'b00));
    check("t4 s1 empty valid", 64'(pop_vld), 64'(2'b00));
    check("t4 rdy restored",   64'(push_rdy), 64'(2'b11));

    // Clear while both FIFOs are full
    step(); push2(32'hE0, 32'hF0); pr = 2'b00; #1;
    step(); push2(32'hE1, 32'hF1); #1;
    expect_pop("t5 fill", 2'b11, 1'b0);
    step(); pv = 2'b11; pd[0] = 32'h77; pd[1] = 32'h88; pr = 2'b11; clear = 1'b1; #1;
    check("t5 full rdy", 64'(push_rdy), 64'(2'b00));
    expect_pop("t5 pre-clear", 2'b11, 1'b0);
    sb0.delete(); sb1.delete();
    step(); clear = 1'b0; pv = '0; #1;
    check("t5 valid", 64'(pop_vld), 64'(2'b00));
    check("t5 skew",  64'(skew), 64'(2'b00));
    check("t5 rdy",   64'(push_rdy), 64'(2'b11));
    step(); push2(32'h60, 32'h70); #1;
    step(); pv = '0; #1;
    expect_pop("t5 post-clear", 2'b11, 1'b1);
    step(); #1;
    check("t5 drained", 64'(pop_vld), 64'(2'b00));

    // Asynchronous reset while the group is valid
    step(); push2(32'h90, 32'h91); pr = 2'b00; #1;
    step(); pv = '0; #1;
    expect_pop("t6 pre-reset", 2'b11, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6 async valid", 64'(pop_vld), 64'(2'b00));
    check("t6 async data0", 64'(pop_dat[0]), 64'(0));
    check("t6 async data1", 64'(pop_dat[1]), 64'(0));
    check("t6 async skew",  64'(skew), 64'(2'b00));
    check("t6 async rdy",   64'(push_rdy), 64'(2'b11));
    sb0.delete(); sb1.delete();
    @(negedge clk);
    rst_ni = 1'b1; pr = 2'b11;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      check("t6 no beat", 64'(pop_vld), 64'(2'b00));
    end
    step(); push2(32'hB5, 32'hC5); #1;
    step(); pv = '0; #1;
    expect_pop("t6 new beat", 2'b11, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
